mdu_unit: RTL and testbench

MDU_UNIT -- requirements
Module: mdu_unit

---
 rtl/mdu_if.sv | 23 ++
 rtl/mdu_unit.sv | 183 ++++++++++++++++++
 tb/tb_mdu_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// Multiply/divide unit bus: op request from decode, HI/LO and stall back.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       md_op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             md_stall;

    modport master (
        output start, md_op, rs_data, rt_data,
        input  busy, hi, lo, md_stall
    );

    modport slave (
        input  start, md_op, rs_data, rt_data,
        output busy, hi, lo, md_stall
    );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO register pair.
// Operands are captured on acceptance; the result is computed from the
// captured copies and committed when the busy down-counter reaches zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no op in flight; accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO
// ST_BUSY  | mult/div in flight; counter runs N-1..0, commit at 0
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES - 1);
    localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t state_q, state_d;

    logic [7:0]       cnt_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic accept, pending, commit, busy;
    logic op_valid, op_long, op_mul;

    // request decode; code 7 is reserved and falls outside op_valid
    assign op_valid = (bus.md_op != OP_NONE) && (bus.md_op <= OP_MTLO);
    assign op_long  = (bus.md_op != OP_NONE) && (bus.md_op <= OP_DIVU);
    assign op_mul   = (bus.md_op == OP_MULT) || (bus.md_op == OP_MULTU);

    // state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // next-state, acceptance and commit strobes; reset blocks acceptance
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        pending = 1'b0;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!reset && bus.start && op_valid) begin
                    accept = 1'b1;
                    if (op_long) begin
                        pending = 1'b1;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == 8'd0) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_BUSY);

    // ---------------- arithmetic on captured operands ----------------
    logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx;
    logic [2*WIDTH-1:0] prod_s, prod_u;

    assign a_sx   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    assign b_sx   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign a_zx   = {{WIDTH{1'b0}}, a_q};
    assign b_zx   = {{WIDTH{1'b0}}, b_q};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;

    // Signed divide on magnitudes: the most-negative / -1 case falls out
    // naturally (quotient wraps back to most-negative, remainder 0).
    logic             a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] quo_mag, rem_mag, quo_s, rem_s;
    logic [WIDTH-1:0] quo_u, rem_u;

    assign a_neg   = a_q[WIDTH-1];
    assign b_neg   = b_q[WIDTH-1];
    assign b_zero  = (b_q == '0);
    assign a_mag   = a_neg ? (~a_q + 1'b1) : a_q;
    assign b_mag   = b_neg ? (~b_q + 1'b1) : b_q;
    assign quo_mag = b_zero ? '0 : (a_mag / b_mag);
    assign rem_mag = b_zero ? '0 : (a_mag % b_mag);
    assign quo_s   = (a_neg ^ b_neg) ? (~quo_mag + 1'b1) : quo_mag;
    assign rem_s   = a_neg ? (~rem_mag + 1'b1) : rem_mag;
    assign quo_u   = b_zero ? '0 : (a_q / b_q);
    assign rem_u   = b_zero ? '0 : (a_q % b_q);

    logic [WIDTH-1:0] res_hi, res_lo;
    logic             res_we;

    // result select for the op held in op_q; divide by zero writes nothing
    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        res_we = 1'b0;
        case (op_q)
            OP_MULT: begin
                res_hi = prod_s[2*WIDTH-1:WIDTH];
                res_lo = prod_s[WIDTH-1:0];
                res_we = 1'b1;
            end
            OP_MULTU: begin
                res_hi = prod_u[2*WIDTH-1:WIDTH];
                res_lo = prod_u[WIDTH-1:0];
                res_we = 1'b1;
            end
            OP_DIV: begin
                if (!b_zero) begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                    res_we = 1'b1;
                end
            end
            OP_DIVU: begin
                if (!b_zero) begin
                    res_hi = rem_u;
                    res_lo = quo_u;
                    res_we = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // operand capture, busy down-counter, MTHI/MTLO writes and commit
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q  <= '0;
            lo_q  <= '0;
            cnt_q <= '0;
            op_q  <= OP_NONE;
            a_q   <= '0;
            b_q   <= '0;
        end else if (accept) begin
            op_q <= bus.md_op;
            a_q  <= bus.rs_data;
            b_q  <= bus.rt_data;
            if (bus.md_op == OP_MTHI) hi_q <= bus.rs_data;
            if (bus.md_op == OP_MTLO) lo_q <= bus.rs_data;
            if (op_mul)       cnt_q <= MULT_LOAD;
            else if (op_long) cnt_q <= DIV_LOAD;
        end else if (commit) begin
            if (res_we) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end else if (busy) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

    assign bus.busy     = busy;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.md_stall = bus.start && (bus.md_op != OP_NONE) && (busy || pending);

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: vector table plus hand-written corner sequences.
module tb_mdu_unit;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    logic [31:0] cur_hi, cur_lo;

    mdu_if #(.WIDTH(32)) bus ();

    mdu_unit #(
        .WIDTH(32),
        .MULT_CYCLES(5),
        .DIV_CYCLES(10)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        bit held_ok;
        n = 0;
        held_ok = 1'b1;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.md_op   = v.op;
        bus.rs_data = v.rs;
        bus.rt_data = v.rt;
        #1;
        if (v.op >= 3'd1 && v.op <= 3'd4)
            chk($sformatf("v%0d stall_at_accept", idx), {63'd0, bus.md_stall}, 64'd1);
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.md_op   = 3'd0;
        bus.rs_data = $urandom;
        bus.rt_data = $urandom;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
            if (bus.hi !== cur_hi || bus.lo !== cur_lo) held_ok = 1'b0;
        end
        chk($sformatf("v%0d busy_cycles", idx), 64'(n), 64'(v.cycles));
        if (v.cycles > 0)
            chk($sformatf("v%0d hold_during_busy", idx), {63'd0, held_ok}, 64'd1);
        chk($sformatf("v%0d hi", idx), {32'd0, bus.hi}, {32'd0, v.hi});
        chk($sformatf("v%0d lo", idx), {32'd0, bus.lo}, {32'd0, v.lo});
        cur_hi = v.hi;
        cur_lo = v.lo;
    endtask

    initial begin
        int n;
        bit stall_ok;
        errors = 0;
        checks = 0;

        //               op     rs            rt            hi            lo            cyc
        vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'd5, 32'h00000011, 32'h0000BEEF, 32'h00000011, 32'hFFFFFFFD, 0};
        vecs[4]  = '{3'd6, 32'h00000022, 32'h0000BEEF, 32'h00000011, 32'h00000022, 0};
        vecs[5]  = '{3'd4, 32'h00000007, 32'h00000000, 32'h00000011, 32'h00000022, 10};
        vecs[6]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[7]  = '{3'd4, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};
        vecs[8]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[9]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[10] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[11] = '{3'd3, 32'h00000000, 32'h00000000, 32'hFFFFFFFE, 32'h00000001, 10};
        vecs[12] = '{3'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 10};
        vecs[13] = '{3'd1, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988, 5};
        vecs[14] = '{3'd7, 32'h00000055, 32'h00000001, 32'hFFFFFFFF, 32'hEDCBA988, 0};
        vecs[15] = '{3'd0, 32'h00000066, 32'h00000001, 32'hFFFFFFFF, 32'hEDCBA988, 0};

        // reset with an MTHI held on the bus: reset wins, then the op is
        // taken in the very first cycle with reset low
        reset       = 1'b1;
        bus.start   = 1'b1;
        bus.md_op   = 3'd5;
        bus.rs_data = 32'h0000DEAD;
        bus.rt_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", {63'd0, bus.busy}, 64'd0);
        chk("reset hi", {32'd0, bus.hi}, 64'd0);
        chk("reset lo", {32'd0, bus.lo}, 64'd0);
        chk("reset md_stall", {63'd0, bus.md_stall}, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.md_op = 3'd0;
        @(negedge clk);
        chk("first_op hi", {32'd0, bus.hi}, 64'h0000DEAD);
        chk("first_op lo", {32'd0, bus.lo}, 64'd0);
        cur_hi = 32'h0000DEAD;
        cur_lo = 32'h0;

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // MULT in flight, MTLO waiting on the bus, reset in busy cycle 3
        @(negedge clk);
        bus.start   = 1'b1;
        bus.md_op   = 3'd1;
        bus.rs_data = 32'd3;
        bus.rt_data = 32'd4;
        @(posedge clk);
        #1;
        bus.md_op   = 3'd6;
        bus.rs_data = 32'h5;
        stall_ok = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (!(bus.busy && bus.md_stall)) stall_ok = 1'b0;
            if (k == 3) reset = 1'b1;
        end
        chk("abort busy_and_stall", {63'd0, stall_ok}, 64'd1);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.md_op = 3'd0;
        @(negedge clk);
        chk("abort busy", {63'd0, bus.busy}, 64'd0);
        chk("abort hi", {32'd0, bus.hi}, 64'd0);
        chk("abort lo", {32'd0, bus.lo}, 64'd0);
        repeat (8) @(negedge clk);
        chk("abort no_late_commit", {bus.hi, bus.lo}, 64'd0);

        // MTHI then DIVU on the next cycle
        @(negedge clk);
        bus.start   = 1'b1;
        bus.md_op   = 3'd5;
        bus.rs_data = 32'hA;
        bus.rt_data = 32'h0;
        @(posedge clk);
        #1;
        bus.md_op   = 3'd4;
        bus.rs_data = 32'd9;
        bus.rt_data = 32'd4;
        @(negedge clk);
        chk("mthi_divu hi_at_t1", {32'd0, bus.hi}, 64'hA);
        chk("mthi_divu busy_at_t1", {63'd0, bus.busy}, 64'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.md_op = 3'd0;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
        end
        chk("mthi_divu busy_cycles", 64'(n), 64'd10);
        chk("mthi_divu hi", {32'd0, bus.hi}, 64'd1);
        chk("mthi_divu lo", {32'd0, bus.lo}, 64'd2);

        // MULTU then MTLO held on the bus: stalled while busy, taken as busy falls
        @(negedge clk);
        bus.start   = 1'b1;
        bus.md_op   = 3'd2;
        bus.rs_data = 32'd3;
        bus.rt_data = 32'd4;
        @(posedge clk);
        #1;
        bus.md_op   = 3'd6;
        bus.rs_data = 32'h77;
        n = 0;
        stall_ok = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
            if (!bus.md_stall || bus.lo !== 32'd2) stall_ok = 1'b0;
        end
        chk("retry busy_cycles", 64'(n), 64'd5);
        chk("retry stall_while_busy", {63'd0, stall_ok}, 64'd1);
        chk("retry product lo", {32'd0, bus.lo}, 64'd12);
        chk("retry product hi", {32'd0, bus.hi}, 64'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.md_op = 3'd0;
        @(negedge clk);
        chk("retry mtlo lo", {32'd0, bus.lo}, 64'h77);
        chk("retry mtlo hi", {32'd0, bus.hi}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
